mem_controller: RTL and testbench
=================================

# mem_controller

Arbitrates load/store requests from `NUM_CONSUMERS` LSU-side consumers onto `NUM_CHANNELS` channels of the banked data memory. It sits between the per-thread load/store units and `data_memory`. Each memory channel is a small independent state machine that:
- claims one pending consumer,
- drives the channel's valid/address/data until the memory returns ready,
- relays the result back,
- waits for the consumer to drop its request.

## Interface
- `NUM_CONSUMERS`, 8: number of requesting consumers.
- `NUM_CHANNELS`, 4: memory channels driven; must be ≤ the memory's channel count.
- `ADDR_BITS`, 8: per-channel address width.
- `DATA_BITS`, 8: data width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `consumer_read_valid`  in  NUM_CONSUMERS  read request per consumer
- `consumer_read_address`  in  NUM_CONSUMERS*ADDR_BITS  flattened, consumer i at `[i*ADDR_BITS +: ADDR_BITS]`
- `consumer_read_ready`  out  NUM_CONSUMERS  read data valid
- `consumer_read_data`  out  NUM_CONSUMERS*DATA_BITS  flattened read data
- `consumer_write_valid`  in  NUM_CONSUMERS  write request
- `consumer_write_address`  in  NUM_CONSUMERS*ADDR_BITS
- `consumer_write_data`  in  NUM_CONSUMERS*DATA_BITS
- `consumer_write_ready`  out  NUM_CONSUMERS  write acknowledged
- `mem_read_valid`  out  NUM_CHANNELS
- `mem_read_address`  out  NUM_CHANNELS*ADDR_BITS
- `mem_read_ready`  in  NUM_CHANNELS
- `mem_read_data`  in  NUM_CHANNELS*DATA_BITS
- `mem_write_valid`  out  NUM_CHANNELS
- `mem_write_address`  out  NUM_CHANNELS*ADDR_BITS
- `mem_write_data`  out  NUM_CHANNELS*DATA_BITS
- `mem_write_ready`  in  NUM_CHANNELS

## Operation
- Per-channel states: IDLE, READ_WAITING, WRITE_WAITING, RELAYING.
- A consumer is *pending* when its read or write valid is high and it is not owned by any channel.
- **IDLE:** the channel selects a pending consumer, records it as owner and marks it busy.
  - If the owner's read valid is high, drive `mem_read_valid`/address and go to READ_WAITING.
  - Otherwise drive `mem_write_valid`/address/data and go to WRITE_WAITING.
  - Read wins when a consumer asserts both; the write stays pending and is served after the read completes.
- **READ_WAITING:** hold `mem_read_valid` until `mem_read_ready`=1. Then:
  - deassert `mem_read_valid`;
  - latch `mem_read_data` into the owner's `consumer_read_data`;
  - set `consumer_read_ready`;
  - go to RELAYING.
- **WRITE_WAITING:** same as READ_WAITING on `mem_write_ready`, setting `consumer_write_ready`.
- **RELAYING:** once the owner's corresponding valid is low, clear its ready, release ownership and return to IDLE.
- **Same-cycle arbitration among channels:** evaluate channels in ascending index order. A consumer claimed by a lower channel is not visible to higher channels in that cycle, so no consumer is ever owned twice.
- Addresses and data pass through unmodified. Bank selection is by channel index inside the memory, so channel k accesses bank k.
- Repeated reads or writes while valid stays high are harmless: the memory rewrites the same data.

## Timing
- Reset value of every output is 0. On reset all channels go to IDLE, owners are released and the priority pointer is cleared to 0.
- Reset mid-transaction aborts it without any consumer ready pulse.
- Cycle numbering for a read, with the consumer's valid high in cycle 0 and a free channel:
  - cycle 1: `mem_read_valid` high;
  - cycle 2: the memory returns ready;
  - cycle 3: `consumer_read_ready` and data presented.
- Writes follow the same schedule with `consumer_write_ready` in cycle 3.
- The consumer ready stays high until the cycle after the consumer drops its valid. The channel is IDLE the following cycle and can claim again one cycle later.
- A consumer must hold address and data stable while its valid is high.
- A consumer that drops valid before its ready is a protocol violation; behaviour is undefined.
- Ready outputs are registered; there is no combinational path from consumer inputs to consumer outputs.

## Configuration
- `MEM_CTRL_ROUND_ROBIN_EN` defined:
  - arbitration starts from a rotating pointer, one past the last consumer granted by any channel;
  - the pointer updates on every grant;
  - a continuously requesting consumer waits at most `ceil(NUM_CONSUMERS/NUM_CHANNELS)` grant rounds.
- Undefined: fixed priority, where the lowest consumer index wins. There is no pointer register.

## Structure
- Package `mem_ctrl_pkg` holds:
  - the channel state enum (`IDLE`, `READ_WAITING`, `WRITE_WAITING`, `RELAYING`);
  - the owner index width constant `$clog2(NUM_CONSUMERS)`.
- One sub-module, `mem_ctrl_arbiter`:
  - inputs: pending mask and pointer;
  - outputs: one-hot grant and valid;
  - used once per channel, with a mask that progressively excludes consumers granted by lower channels.

## Test plan
- **Single read.** Memory initialised to i%13; consumer 0 reads address 5 on an idle controller → `consumer_read_ready[0]`=1 in cycle 3 with data 5; ready falls one cycle after valid drops.
- **Write then read.** Consumer 1 writes 0xA5 to address 20 → `consumer_write_ready[1]` in cycle 3; a subsequent read of address 20 through the same channel returns 0xA5.
- **Contention.** All 8 consumers read simultaneously with 4 channels → consumers 0–3 served first, 4–7 after release; no consumer ever sees two ready pulses per request.
- **Round robin (macro defined).** Consumers 0 and 5 request continuously with `NUM_CHANNELS`=1 → grants alternate 0, 5, 0, 5. Macro undefined → consumer 0 wins every arbitration round.
- **Simultaneous read and write.** Consumer 2 asserts both → the read completes first, then the write is served.
- **Reset mid-transaction.** Assert `reset` in cycle 2 of a read → all outputs 0 next cycle, no `consumer_read_ready`; the request re-issued after reset completes normally.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: channel state encoding and sizing helper shared by the
// memory controller and its arbiter.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ_WAITING,
    WRITE_WAITING,
    RELAYING
  } chan_state_t;

  // Owner index width, $clog2(NUM_CONSUMERS), kept at least one bit wide.
  function automatic int unsigned owner_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_ctrl_arbiter.sv
// mem_ctrl_arbiter: picks one pending consumer, scanning upward from the
// pointer with wrap-around. A pointer tied to zero gives fixed priority.
module mem_ctrl_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CONSUMERS = 8,
  parameter int unsigned PTR_BITS      = 3
) (
  input  logic [NUM_CONSUMERS-1:0] pending,
  input  logic [PTR_BITS-1:0]      pointer,
  output logic [NUM_CONSUMERS-1:0] grant,
  output logic                     valid
);

  // First pending consumer at or after the pointer wins.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    grant = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
      idx = (32'(pointer) + i) % NUM_CONSUMERS;
      if (!valid && pending[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_controller.sv
// mem_controller: arbitrates consumer load/store requests onto memory
// channels; each channel runs IDLE -> *_WAITING -> RELAYING -> IDLE.
// Optional macro MEM_CTRL_ROUND_ROBIN_EN: rotating arbitration pointer
// instead of fixed lowest-index priority.
module mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CONSUMERS = 8,
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int unsigned OB = owner_bits(NUM_CONSUMERS);

  chan_state_t              state_q [NUM_CHANNELS];
  chan_state_t              state_d [NUM_CHANNELS];
  logic [OB-1:0]            owner_q [NUM_CHANNELS];
  logic [OB-1:0]            gidx    [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] mask    [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] grant   [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  gvalid, idle, claim, done, rel, is_read_q;
  logic [NUM_CONSUMERS-1:0] busy_q, pending;
  logic [OB-1:0]            ptr;

  assign pending = (consumer_read_valid | consumer_write_valid) & ~busy_q;
  assign mask[0] = pending;

  // Each channel sees the pending mask minus whatever lower idle channels grant
  // this cycle, so one consumer is never claimed twice.
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    assign idle[c] = (state_q[c] == IDLE);
    mem_ctrl_arbiter #(
      .NUM_CONSUMERS(NUM_CONSUMERS),
      .PTR_BITS     (OB)
    ) u_arb (
      .pending(mask[c]),
      .pointer(ptr),
      .grant  (grant[c]),
      .valid  (gvalid[c])
    );
    if (c + 1 < NUM_CHANNELS) begin : g_next
      assign mask[c+1] = mask[c] & ~(idle[c] ? grant[c] : '0);
    end
  end

`ifdef MEM_CTRL_ROUND_ROBIN_EN
  logic [OB-1:0] ptr_q, ptr_d;
  assign ptr = ptr_q;

  // Pointer moves one past the consumer granted by the highest claiming channel.
  always_comb begin
    ptr_d = ptr_q;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      if (claim[c]) begin
        ptr_d = (32'(gidx[c]) == NUM_CONSUMERS - 1) ? '0 : gidx[c] + OB'(1);
      end
    end
  end

  // Rotating pointer register.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  assign ptr = '0;
`endif

  // Per-channel next state and claim/complete/release strobes.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      state_d[c] = state_q[c];
      claim[c]   = 1'b0;
      done[c]    = 1'b0;
      rel[c]     = 1'b0;
      gidx[c]    = '0;
      for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
        if (grant[c][i]) gidx[c] = OB'(i);
      end
      unique case (state_q[c])
        IDLE: if (gvalid[c]) begin
          claim[c]   = 1'b1;
          state_d[c] = consumer_read_valid[gidx[c]] ? READ_WAITING : WRITE_WAITING;
        end
        READ_WAITING: if (mem_read_ready[c]) begin
          done[c]    = 1'b1;
          state_d[c] = RELAYING;
        end
        WRITE_WAITING: if (mem_write_ready[c]) begin
          done[c]    = 1'b1;
          state_d[c] = RELAYING;
        end
        RELAYING: if (is_read_q[c] ? !consumer_read_valid[owner_q[c]]
                                   : !consumer_write_valid[owner_q[c]]) begin
          rel[c]     = 1'b1;
          state_d[c] = IDLE;
        end
        default: state_d[c] = IDLE;
      endcase
    end
  end

  // State, ownership and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= IDLE;
        owner_q[c] <= '0;
      end
      is_read_q            <= '0;
      busy_q               <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= '0;
      mem_read_address     <= '0;
      mem_write_valid      <= '0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        if (claim[c]) begin
          owner_q[c]        <= gidx[c];
          busy_q[gidx[c]]   <= 1'b1;
          is_read_q[c]      <= consumer_read_valid[gidx[c]];
          if (consumer_read_valid[gidx[c]]) begin
            mem_read_valid[c] <= 1'b1;
            mem_read_address[c*ADDR_BITS +: ADDR_BITS] <=
              consumer_read_address[32'(gidx[c])*ADDR_BITS +: ADDR_BITS];
          end else begin
            mem_write_valid[c] <= 1'b1;
            mem_write_address[c*ADDR_BITS +: ADDR_BITS] <=
              consumer_write_address[32'(gidx[c])*ADDR_BITS +: ADDR_BITS];
            mem_write_data[c*DATA_BITS +: DATA_BITS] <=
              consumer_write_data[32'(gidx[c])*DATA_BITS +: DATA_BITS];
          end
        end
        if (done[c]) begin
          if (is_read_q[c]) begin
            mem_read_valid[c]                <= 1'b0;
            consumer_read_ready[owner_q[c]]  <= 1'b1;
            consumer_read_data[32'(owner_q[c])*DATA_BITS +: DATA_BITS] <=
              mem_read_data[c*DATA_BITS +: DATA_BITS];
          end else begin
            mem_write_valid[c]               <= 1'b0;
            consumer_write_ready[owner_q[c]] <= 1'b1;
          end
        end
        if (rel[c]) begin
          busy_q[owner_q[c]] <= 1'b0;
          if (is_read_q[c]) consumer_read_ready[owner_q[c]]  <= 1'b0;
          else              consumer_write_ready[owner_q[c]] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_controller.sv
// tb_mem_controller: table vectors, directed corner sequences and a random
// request phase checked against a banked memory and per-consumer protocol model.
module tb_mem_controller;

  localparam int NC  = 8;
  localparam int NCH = 4;
  localparam int AB  = 8;
  localparam int DB  = 8;

  logic clk, reset;

  // main instance (4 channels)
  logic [NC-1:0]     crv, crr, cwv, cwr;
  logic [NC*AB-1:0]  cra, cwa;
  logic [NC*DB-1:0]  crd, cwd;
  logic [NCH-1:0]    mrv, mrr, mwv, mwr;
  logic [NCH*AB-1:0] mra, mwa;
  logic [NCH*DB-1:0] mrd, mwd;

  // single-channel instance for arbitration order
  logic [NC-1:0]    crv1, crr1, cwv1, cwr1;
  logic [NC*AB-1:0] cra1, cwa1;
  logic [NC*DB-1:0] crd1, cwd1;
  logic [0:0]       mrv1, mrr1, mwv1, mwr1;
  logic [AB-1:0]    mra1, mwa1;
  logic [DB-1:0]    mrd1, mwd1;

  int checks, failures;

  mem_controller #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(crv), .consumer_read_address(cra),
    .consumer_read_ready(crr), .consumer_read_data(crd),
    .consumer_write_valid(cwv), .consumer_write_address(cwa),
    .consumer_write_data(cwd), .consumer_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_address(mra),
    .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa),
    .mem_write_data(mwd), .mem_write_ready(mwr));

  mem_controller #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(1), .ADDR_BITS(AB), .DATA_BITS(DB)) dut1 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(crv1), .consumer_read_address(cra1),
    .consumer_read_ready(crr1), .consumer_read_data(crd1),
    .consumer_write_valid(cwv1), .consumer_write_address(cwa1),
    .consumer_write_data(cwd1), .consumer_write_ready(cwr1),
    .mem_read_valid(mrv1), .mem_read_address(mra1),
    .mem_read_ready(mrr1), .mem_read_data(mrd1),
    .mem_write_valid(mwv1), .mem_write_address(mwa1),
    .mem_write_data(mwd1), .mem_write_ready(mwr1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Banked memory: bank k behind channel k, one-cycle registered ready.
  logic       mem_reinit;
  logic [7:0] bank  [NCH][256];
  logic [7:0] bank1 [256];

  always @(posedge clk) begin
    for (int ch = 0; ch < NCH; ch++) begin
      mrr[ch] <= mrv[ch] & ~mrr[ch];
      mwr[ch] <= mwv[ch] & ~mwr[ch];
      if (mrv[ch]) mrd[ch*DB +: DB] <= bank[ch][mra[ch*AB +: AB]];
      if (mwv[ch]) bank[ch][mwa[ch*AB +: AB]] <= mwd[ch*DB +: DB];
      if (mem_reinit) begin
        mrr[ch] <= 1'b0;
        mwr[ch] <= 1'b0;
        for (int a = 0; a < 256; a++) bank[ch][a] <= 8'(a % 13);
      end
    end
    mrr1 <= mrv1 & ~mrr1;
    mwr1 <= mwv1 & ~mwr1;
    if (mrv1) mrd1 <= bank1[mra1];
    if (mwv1) bank1[mwa1] <= mwd1;
    if (mem_reinit) begin
      mrr1 <= 1'b0;
      mwr1 <= 1'b0;
      for (int a = 0; a < 256; a++) bank1[a] <= 8'(a % 13);
    end
  end

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    int cons;
    bit wr;
    int addr;
    int wdata;
    int exp_data;
    int exp_lat;
  } vec_t;

  // One isolated transaction on an idle controller; served by channel 0 / bank 0.
  task automatic run_vec(input vec_t v);
    int  lat;
    bit  seen;
    logic [NC-1:0] others;
    if (v.wr) begin
      cwa[v.cons*AB +: AB] = 8'(v.addr);
      cwd[v.cons*DB +: DB] = 8'(v.wdata);
      cwv[v.cons] = 1'b1;
    end else begin
      cra[v.cons*AB +: AB] = 8'(v.addr);
      crv[v.cons] = 1'b1;
    end
    @(negedge clk);
    chk("vec_mem_valid_cycle1", int'(v.wr ? mwv[0] : mrv[0]), 1);
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat < 12) begin
      @(negedge clk);
      lat++;
      seen = v.wr ? cwr[v.cons] : crr[v.cons];
    end
    chk("vec_latency", lat, v.exp_lat);
    others = (crr | cwr) & ~(NC'(1) << v.cons);
    chk("vec_other_ready", int'(others), 0);
    if (!v.wr) chk("vec_rdata", int'(crd[v.cons*DB +: DB]), v.exp_data);
    crv[v.cons] = 1'b0;
    cwv[v.cons] = 1'b0;
    @(negedge clk);
    chk("vec_ready_fall", int'(crr[v.cons] | cwr[v.cons]), 0);
    @(negedge clk);
  endtask

  // random-phase consumer model
  int st [NC];
  int age [NC];
  int hold [NC];
  int raddr [NC];
  bit rw [NC];

  function automatic bit all_idle();
    for (int i = 0; i < NC; i++) if (st[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [8];
    int   t [NC];
    int   pulses [NC];
    int   tmin, tsec, lat, ng;
    int   got [4];
    int   exp_rr [4];
    bit   rearm [NC];
    logic [NC-1:0] prev, m1, m2;
    logic rdy, oth;

    checks = 0; failures = 0;
    crv = '0; cwv = '0; cra = '0; cwa = '0; cwd = '0;
    crv1 = '0; cwv1 = '0; cra1 = '0; cwa1 = '0; cwd1 = '0;
    reset = 1'b1; mem_reinit = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs_dut", int'(|{crr, crd, cwr, mrv, mra, mwv, mwa, mwd}), 0);
    chk("reset_outputs_dut1", int'(|{crr1, crd1, cwr1, mrv1, mra1, mwv1, mwa1, mwd1}), 0);
    reset = 1'b0; mem_reinit = 1'b0;
    @(negedge clk);

    // table vectors: {consumer, write, addr, wdata, expected rdata, latency}
    vecs[0] = '{0, 1'b0,   5, 0,     5, 3};
    vecs[1] = '{1, 1'b1,  20, 8'hA5, 0, 3};
    vecs[2] = '{1, 1'b0,  20, 0, 8'hA5, 3};
    vecs[3] = '{3, 1'b0, 255, 0,     8, 3};
    vecs[4] = '{6, 1'b1,   0, 8'h3C, 0, 3};
    vecs[5] = '{6, 1'b0,   0, 0, 8'h3C, 3};
    vecs[6] = '{7, 1'b0, 100, 0,     9, 3};
    vecs[7] = '{4, 1'b0,  13, 0,     0, 3};
    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    // consumer 2 asserts read and write together: read first, then write
    cra[2*AB +: AB] = 8'd40;
    cwa[2*AB +: AB] = 8'd41;
    cwd[2*DB +: DB] = 8'h77;
    crv[2] = 1'b1; cwv[2] = 1'b1;
    lat = 0;
    while (!crr[2] && lat < 12) begin @(negedge clk); lat++; end
    chk("rw_read_first_ready", int'(crr[2]), 1);
    chk("rw_read_first_no_wready", int'(cwr[2]), 0);
    chk("rw_read_data", int'(crd[2*DB +: DB]), 40 % 13);
    crv[2] = 1'b0;
    lat = 0;
    while (!cwr[2] && lat < 12) begin @(negedge clk); lat++; end
    chk("rw_write_ready", int'(cwr[2]), 1);
    chk("rw_write_no_rready", int'(crr[2]), 0);
    cwv[2] = 1'b0;
    repeat (2) @(negedge clk);
    run_vec('{2, 1'b0, 41, 0, 8'h77, 3});

    // contention: all consumers read at once
    do_reset();
    for (int i = 0; i < NC; i++) begin
      t[i] = -1; pulses[i] = 0;
      cra[i*AB +: AB] = 8'(30 + i);
    end
    crv = '1;
    prev = '0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NC; i++) begin
        if (crr[i] && !prev[i]) pulses[i]++;
        if (crr[i] && crv[i]) begin
          t[i] = cyc;
          chk("contention_rdata", int'(crd[i*DB +: DB]), (30 + i) % 13);
          crv[i] = 1'b0;
        end
      end
      prev = crr;
    end
    tmin = 1000; tsec = 1000;
    for (int i = 0; i < NC; i++) if (t[i] > 0 && t[i] < tmin) tmin = t[i];
    for (int i = 0; i < NC; i++) if (t[i] > tmin && t[i] < tsec) tsec = t[i];
    m1 = '0; m2 = '0;
    for (int i = 0; i < NC; i++) begin
      m1[i] = (t[i] == tmin);
      m2[i] = (t[i] == tsec);
    end
    chk("contention_first_wave", int'(m1), 8'h0F);
    chk("contention_second_wave", int'(m2), 8'hF0);
    for (int i = 0; i < NC; i++) chk("contention_single_pulse", pulses[i], 1);

    // reset asserted in cycle 2 of a read
    cra[0 +: AB] = 8'd9;
    crv[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_outputs_zero", int'(|{crr, crd, cwr, mrv, mra, mwv, mwa, mwd}), 0);
    reset = 1'b0;
    lat = 0;
    while (!crr[0] && lat < 12) begin @(negedge clk); lat++; end
    chk("midreset_reissue_latency", lat, 3);
    chk("midreset_reissue_data", int'(crd[0 +: DB]), 9);
    crv[0] = 1'b0;
    repeat (2) @(negedge clk);

    // arbitration order, one channel, consumers 0 and 5 requesting continuously
`ifdef MEM_CTRL_ROUND_ROBIN_EN
    exp_rr = '{0, 5, 0, 5};
`else
    exp_rr = '{0, 0, 0, 0};
`endif
    do_reset();
    got = '{-1, -1, -1, -1};
    ng = 0;
    rearm = '{default: 1'b0};
    cra1[0 +: AB]    = 8'd0;
    cra1[5*AB +: AB] = 8'd5;
    crv1[0] = 1'b1; crv1[5] = 1'b1;
    for (int cyc = 0; cyc < 80 && ng < 4; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NC; i++) begin
        if (rearm[i]) begin
          crv1[i] = 1'b1;
          rearm[i] = 1'b0;
        end else if (crr1[i] && crv1[i] && ng < 4) begin
          got[ng] = i;
          ng++;
          crv1[i] = 1'b0;
          rearm[i] = 1'b1;
        end
      end
    end
    for (int k = 0; k < 4; k++) chk("arb_grant_order", got[k], exp_rr[k]);
    crv1 = '0;

    // random phase: writes store addr%13 so every bank stays identical
    mem_reinit = 1'b1;
    do_reset();
    mem_reinit = 1'b0;
    for (int i = 0; i < NC; i++) begin st[i] = 0; age[i] = 0; hold[i] = 0; end
    for (int cyc = 0; cyc < 2600; cyc++) begin
      @(negedge clk);
      if (cyc >= 2000 && all_idle()) break;
      chk("rand_ready_bound", int'($countones(crr | cwr) <= NCH), 1);
      for (int i = 0; i < NC; i++) begin
        rdy = rw[i] ? cwr[i] : crr[i];
        oth = rw[i] ? crr[i] : cwr[i];
        case (st[i])
          0: begin
            chk("rand_idle_no_ready", int'(crr[i] | cwr[i]), 0);
            if (cyc < 2000 && $urandom_range(0, 3) == 0) begin
              rw[i]    = 1'($urandom_range(0, 1));
              raddr[i] = int'($urandom_range(0, 255));
              age[i]   = 0;
              st[i]    = 1;
              if (rw[i]) begin
                cwa[i*AB +: AB] = 8'(raddr[i]);
                cwd[i*DB +: DB] = 8'(raddr[i] % 13);
                cwv[i] = 1'b1;
              end else begin
                cra[i*AB +: AB] = 8'(raddr[i]);
                crv[i] = 1'b1;
              end
            end
          end
          1: begin
            age[i]++;
            chk("rand_no_wrong_ready", int'(oth), 0);
            if (rdy) begin
              chk("rand_min_latency", int'(age[i] >= 3), 1);
              if (!rw[i]) chk("rand_rdata", int'(crd[i*DB +: DB]), raddr[i] % 13);
              hold[i] = int'($urandom_range(0, 2));
              st[i] = 2;
            end else if (age[i] > 300) begin
              chk("rand_timeout", int'(rdy), 1);
              crv[i] = 1'b0; cwv[i] = 1'b0;
              st[i] = 0;
            end
          end
          2: begin
            chk("rand_ready_held", int'(rdy), 1);
            if (hold[i] == 0) begin
              crv[i] = 1'b0; cwv[i] = 1'b0;
              st[i] = 3;
            end else begin
              hold[i]--;
            end
          end
          default: begin
            chk("rand_ready_fall", int'(crr[i] | cwr[i]), 0);
            st[i] = 0;
          end
        endcase
      end
    end
    chk("rand_all_drained", int'(all_idle()), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
